// File: rtl/meas_fmt_pkg.sv
// Shared constants, state encoding and digit helper for the measurement ASCII formatter.
package meas_fmt_pkg;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } fmt_state_t;

    function automatic logic [7:0] digit_to_ascii(logic [3:0] d);
        return ASC_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/meas_ascii_fmt_if.sv
// Sample-in / line-out bundle between the sample source, the formatter and uart_top.
interface meas_ascii_fmt_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CHAR_NR = 8
);
    logic [DATA_W-1:0]    sample_i;
    logic                 sample_valid_i;
    logic                 clr_i;
    logic                 tx_busy_i;
    logic [CHAR_NR*8-1:0] char_array_o;
    logic                 char_array_update_o;
    logic                 busy_o;
    logic                 overrun_o;

    modport master (
        output sample_i, sample_valid_i, clr_i, tx_busy_i,
        input  char_array_o, char_array_update_o, busy_o, overrun_o
    );

    modport slave (
        input  sample_i, sample_valid_i, clr_i, tx_busy_i,
        output char_array_o, char_array_update_o, busy_o, overrun_o
    );
endinterface

// File: rtl/meas_ascii_fmt_bin2bcd_seq.sv
// Iterative double-dabble: one magnitude bit per clock, MSB first, done_o on the final shift.
module bin2bcd_seq #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIG_NR = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_W-1:0]     bin_i,
    output logic                  done_o,
    output logic [DIG_NR*4-1:0]   bcd_o
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   shreg_q;
    logic [DIG_NR*4-1:0] bcd_q;
    logic [DIG_NR*4-1:0] bcd_adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                run_q;
    logic                last;

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIG_NR; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign last = run_q && (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (abort_i) begin
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            shreg_q <= bin_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            bcd_q   <= {bcd_adj[DIG_NR*4-2:0], shreg_q[DATA_W-1]};
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o = last;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/meas_ascii_fmt.sv
// Signed sample -> fixed-width ASCII line for uart_top, with 1-deep pending sample buffer.
module meas_ascii_fmt
    import meas_fmt_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DIG_NR    = 5,
    parameter int unsigned DP_POS    = 3,
    parameter logic [7:0]  UNIT_CHAR = 8'h56
) (
    input  logic              clk,
    input  logic              rst_n,
    meas_ascii_fmt_if.slave   bus
);
    localparam int unsigned CHAR_NR = DIG_NR + 3;
    localparam int unsigned INT_NR  = DIG_NR - DP_POS;
    localparam longint unsigned POW10 = longint'(10) ** DIG_NR;
    localparam longint unsigned HALF  = longint'(1) << (DATA_W - 1);

    if (POW10 <= HALF) begin : g_range_chk
        $error("meas_ascii_fmt: DIG_NR too small for DATA_W");
    end
    if (DP_POS < 1 || DP_POS > DIG_NR - 1) begin : g_dp_chk
        $error("meas_ascii_fmt: DP_POS out of range");
    end

    fmt_state_t           state_q, state_d;
    logic                 sign_q, sign_d;
    logic                 pend_q, pend_d;
    logic [DATA_W-1:0]    pend_data_q, pend_data_d;
    logic [CHAR_NR*8-1:0] line_q, line_d, line_fmt;
    logic                 upd_q, upd_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic                 start;
    logic [DATA_W-1:0]    sel_sample;
    logic [DATA_W-1:0]    mag;
    logic                 conv_done;
    logic [DIG_NR*4-1:0]  bcd;
    logic                 nz;

    // Two's complement negate is exact for the most negative value when read unsigned.
    assign mag = sel_sample[DATA_W-1] ? (~sel_sample + DATA_W'(1)) : sel_sample;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIG_NR (DIG_NR)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .abort_i (bus.clr_i),
        .bin_i   (mag),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    always_comb begin
        line_fmt = {CHAR_NR{ASC_SPACE}};
        nz       = 1'b0;
        line_fmt[CHAR_NR*8-1 -: 8] = sign_q ? ASC_MINUS : ASC_PLUS;
        for (int unsigned i = 0; i < INT_NR; i++) begin
            if (bcd[(DIG_NR-1-i)*4 +: 4] != 4'd0) begin
                nz = 1'b1;
            end
            // Leading zeros blank, but the units digit always prints.
            if (nz || (i == INT_NR - 1)) begin
                line_fmt[(DIG_NR+1-i)*8 +: 8] = digit_to_ascii(bcd[(DIG_NR-1-i)*4 +: 4]);
            end
        end
        line_fmt[(DP_POS+1)*8 +: 8] = ASC_DOT;
        for (int unsigned j = 0; j < DP_POS; j++) begin
            line_fmt[(DP_POS-j)*8 +: 8] = digit_to_ascii(bcd[(DP_POS-1-j)*4 +: 4]);
        end
        line_fmt[7:0] = UNIT_CHAR;
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        line_d      = line_q;
        upd_d       = 1'b0;
        ovr_d       = 1'b0;
        start       = 1'b0;
        sel_sample  = bus.sample_i;

        if (bus.clr_i) begin
            state_d = IDLE;
            pend_d  = 1'b0;
            line_d  = {CHAR_NR{ASC_SPACE}};
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.sample_valid_i) begin
                        start      = 1'b1;
                        sel_sample = bus.sample_i;
                        pend_d     = 1'b0;
                        state_d    = CONV;
                    end else if (pend_q) begin
                        start      = 1'b1;
                        sel_sample = pend_data_q;
                        pend_d     = 1'b0;
                        state_d    = CONV;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (!bus.tx_busy_i) begin
                        line_d  = line_fmt;
                        upd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if ((state_q != IDLE) && bus.sample_valid_i) begin
                pend_d      = 1'b1;
                pend_data_d = bus.sample_i;
                ovr_d       = pend_q;
            end
            if (start) begin
                sign_d = sel_sample[DATA_W-1];
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            line_q      <= {CHAR_NR{ASC_SPACE}};
            upd_q       <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            line_q      <= line_d;
            upd_q       <= upd_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.char_array_o        = line_q;
    assign bus.char_array_update_o = upd_q;
    assign bus.busy_o              = busy_q;
    assign bus.overrun_o           = ovr_q;

endmodule
